// File: rtl/mdr_driver.sv
// mdr_driver: command-side initiator for the mdr (multiply/divide/root) unit.
//
// Accepts one (op, X, Y) command over a valid/ready handshake. It then pulses
// mdr's active-low start strobe and presents each operand on o_data when mdr
// asks for it. Each operand gets one setup cycle before its active-low load
// strobe. The driver then waits for i_done and returns result, remainder and
// error status over a valid/ready response handshake. Every wait state is
// guarded by a TIMEOUT-cycle watchdog.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready   command handshake (ready only when idle)
//   i_cmd_op/i_cmd_x/i_cmd_y  operation and operands (Y ignored for ROOT)
//   o_start/o_load            active-low strobes to mdr
//   o_data/o_op               operand bus and operation select to mdr
//   i_load_x/i_load_y         mdr operand requests
//   i_done/i_result/i_remainder/i_error  mdr completion interface
//   o_rsp_valid/i_rsp_ready   response handshake
//   o_rsp_result/o_rsp_remainder/o_rsp_error/o_rsp_timeout  response fields
module mdr_driver #(
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [1:0]    i_cmd_op,
  input  logic [DW-1:0] i_cmd_x,
  input  logic [DW-1:0] i_cmd_y,
  output logic          o_start,
  output logic          o_load,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_op,
  input  logic          i_load_x,
  input  logic          i_load_y,
  input  logic          i_done,
  input  logic [DW-1:0] i_result,
  input  logic [DW-1:0] i_remainder,
  input  logic          i_error,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [DW-1:0] o_rsp_result,
  output logic [DW-1:0] o_rsp_remainder,
  output logic          o_rsp_error,
  output logic          o_rsp_timeout
);

  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [1:0]    OP_ROOT   = 2'd2;
  localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_START   = 4'd1,
    S_WAIT_X  = 4'd2,
    S_SETUP_X = 4'd3,
    S_PULSE_X = 4'd4,
    S_WAIT_Y  = 4'd5,
    S_SETUP_Y = 4'd6,
    S_PULSE_Y = 4'd7,
    S_BUSY    = 4'd8,
    S_RESP    = 4'd9
  } state_t;

  state_t        state_q;
  logic [DW-1:0] x_q;
  logic [DW-1:0] y_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc_d;
  logic          tmo_hit_d;
  logic          cmd_ready_q;
  logic          start_q;
  logic          load_q;
  logic [DW-1:0] data_q;
  logic [1:0]    op_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_result_q;
  logic [DW-1:0] rsp_rem_q;
  logic          rsp_error_q;
  logic          rsp_timeout_q;

  // Watchdog increment and limit detection; the counter stops at TIMEOUT so it never wraps.
  always_comb begin
    cnt_inc_d = cnt_q + CW'(1);
    tmo_hit_d = (cnt_inc_d == TMO_LIMIT);
  end

  // Transaction sequencer: state, watchdog and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      start_q       <= 1'b1;
      load_q        <= 1'b1;
      data_q        <= '0;
      op_q          <= 2'd0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_rem_q     <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (i_cmd_valid) begin
            x_q         <= i_cmd_x;
            y_q         <= (i_cmd_op == OP_ROOT) ? '0 : i_cmd_y;
            op_q        <= i_cmd_op;
            cmd_ready_q <= 1'b0;
            start_q     <= 1'b0;
            state_q     <= S_START;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_START: begin
          cnt_q   <= '0;
          start_q <= 1'b1;
          state_q <= S_WAIT_X;
        end
        S_WAIT_X, S_WAIT_Y: begin
          // Error outranks the operand request; any real event outranks the watchdog.
          if (i_error) begin
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b1;
            rsp_result_q  <= '0;
            rsp_rem_q     <= '0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b0;
            state_q       <= S_RESP;
          end else if ((state_q == S_WAIT_X) ? i_load_x : i_load_y) begin
            cnt_q   <= '0;
            data_q  <= (state_q == S_WAIT_X) ? x_q : y_q;
            state_q <= (state_q == S_WAIT_X) ? S_SETUP_X : S_SETUP_Y;
          end else if (tmo_hit_d) begin
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b1;
            rsp_result_q  <= '0;
            rsp_rem_q     <= '0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_SETUP_X, S_SETUP_Y: begin
          cnt_q   <= '0;
          load_q  <= 1'b0;
          state_q <= (state_q == S_SETUP_X) ? S_PULSE_X : S_PULSE_Y;
        end
        S_PULSE_X, S_PULSE_Y: begin
          cnt_q   <= '0;
          load_q  <= 1'b1;
          state_q <= (state_q == S_PULSE_X) ? S_WAIT_Y : S_BUSY;
        end
        S_BUSY: begin
          if (i_done) begin
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b1;
            rsp_result_q  <= i_result;
            rsp_rem_q     <= i_remainder;
            rsp_error_q   <= i_error;
            rsp_timeout_q <= 1'b0;
            state_q       <= S_RESP;
          end else if (tmo_hit_d) begin
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b1;
            rsp_result_q  <= '0;
            rsp_rem_q     <= '0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_RESP: begin
          cnt_q <= '0;
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            op_q        <= 2'd0;
            state_q     <= S_IDLE;
          end else begin
            rsp_valid_q <= 1'b1;
          end
        end
        default: begin
          cnt_q       <= '0;
          cmd_ready_q <= 1'b1;
          start_q     <= 1'b1;
          load_q      <= 1'b1;
          op_q        <= 2'd0;
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready     = cmd_ready_q;
  assign o_start         = start_q;
  assign o_load          = load_q;
  assign o_data          = data_q;
  assign o_op            = op_q;
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_result    = rsp_result_q;
  assign o_rsp_remainder = rsp_rem_q;
  assign o_rsp_error     = rsp_error_q;
  assign o_rsp_timeout   = rsp_timeout_q;

endmodule

// File: tb/tb_mdr_driver.sv
// tb_mdr_driver: randomized self-checking bench for mdr_driver.
// Each transaction is planned up front (operand-request, done and response
// delays, optional abort or reset). The expected value of every output in
// every cycle is derived from that plan by timeline arithmetic. A single
// negedge process compares the DUT outputs against these expected values.
module tb_mdr_driver;
  localparam int DW  = 16;
  localparam int TMO = 16;
  localparam logic [1:0] OP_MULT = 2'd0;
  localparam logic [1:0] OP_DIV  = 2'd1;
  localparam logic [1:0] OP_ROOT = 2'd2;

  logic clk = 1'b0;
  logic rst;
  logic i_cmd_valid, o_cmd_ready;
  logic [1:0] i_cmd_op, o_op;
  logic [DW-1:0] i_cmd_x, i_cmd_y, o_data, i_result, i_remainder, o_rsp_result, o_rsp_remainder;
  logic o_start, o_load, i_load_x, i_load_y, i_done, i_error;
  logic o_rsp_valid, i_rsp_ready, o_rsp_error, o_rsp_timeout;

  always #5 clk = ~clk;

  mdr_driver #(.DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_x(i_cmd_x), .i_cmd_y(i_cmd_y),
    .o_start(o_start), .o_load(o_load), .o_data(o_data), .o_op(o_op),
    .i_load_x(i_load_x), .i_load_y(i_load_y), .i_done(i_done),
    .i_result(i_result), .i_remainder(i_remainder), .i_error(i_error),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_result(o_rsp_result), .o_rsp_remainder(o_rsp_remainder),
    .o_rsp_error(o_rsp_error), .o_rsp_timeout(o_rsp_timeout)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle
  logic e_cmd_ready, e_start, e_load, e_rsp_valid, e_rsp_error, e_rsp_timeout;
  logic [1:0] e_op;
  logic [DW-1:0] e_data, e_rsp_result, e_rsp_rem;

  // Values held over from the previous transaction
  logic [DW-1:0] prev_data = '0, prev_res = '0, prev_rem = '0;
  logic prev_err = 1'b0, prev_to = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all DUT outputs against the expected values each cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready", 32'(o_cmd_ready), 32'(e_cmd_ready));
      check("start", 32'(o_start), 32'(e_start));
      check("load", 32'(o_load), 32'(e_load));
      check("data", 32'(o_data), 32'(e_data));
      check("op", 32'(o_op), 32'(e_op));
      check("rsp_valid", 32'(o_rsp_valid), 32'(e_rsp_valid));
      check("rsp_result", 32'(o_rsp_result), 32'(e_rsp_result));
      check("rsp_rem", 32'(o_rsp_remainder), 32'(e_rsp_rem));
      check("rsp_error", 32'(o_rsp_error), 32'(e_rsp_error));
      check("rsp_timeout", 32'(o_rsp_timeout), 32'(e_rsp_timeout));
    end
  end

  // Behavioural mdr: what the unit would answer for a given command.
  task automatic mdr_eval(input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                          output logic [DW-1:0] res, output logic [DW-1:0] rem, output logic err);
    int s;
    res = '0; rem = '0; err = 1'b0;
    if (op == OP_MULT) begin
      res = DW'(32'(x) * 32'(y));
    end else if (op == OP_DIV) begin
      if (y == '0) begin
        res = '1; rem = x; err = 1'b1;
      end else begin
        res = x / y; rem = x % y;
      end
    end else begin
      s = 0;
      for (int k = 0; k < 256; k++) if (k * k <= int'(x)) s = k;
      res = DW'(s); rem = DW'(int'(x) - s * s);
    end
  endtask

  // Plan one transaction, drive it cycle by cycle and publish the expected outputs.
  // Delays >= TMO mean the event never arrives. abort_at: 0 none, 1 in WAIT_X, 2 in WAIT_Y.
  // rst_busy >= 0 asserts reset that many cycles after entering BUSY.
  task automatic run_txn(input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y,
                         input int dx, input int dy, input int dd, input int dr,
                         input int abort_at, input int rst_busy);
    logic [DW-1:0] yv, res, rem, n_res, n_rem;
    logic merr, n_err, n_to;
    int wx, sx, px, wy, sy, py, b, resp_c, idle_c, rst_c, last, lim;
    yv = (op == OP_ROOT) ? '0 : y;
    mdr_eval(op, x, yv, res, rem, merr);
    sx = -1; px = -1; wy = -1; sy = -1; py = -1; b = -1; rst_c = -1;
    wx = 2;
    n_res = '0; n_rem = '0; n_err = 1'b1; n_to = 1'b0;
    if (abort_at == 1 && dx < TMO) resp_c = wx + dx + 1;
    else if (dx >= TMO) begin resp_c = wx + TMO; n_to = 1'b1; end
    else begin
      sx = wx + dx + 1; px = sx + 1; wy = px + 1;
      if (abort_at == 2 && dy < TMO) resp_c = wy + dy + 1;
      else if (dy >= TMO) begin resp_c = wy + TMO; n_to = 1'b1; end
      else begin
        sy = wy + dy + 1; py = sy + 1; b = py + 1;
        if (dd >= TMO) begin resp_c = b + TMO; n_to = 1'b1; end
        else begin resp_c = b + dd + 1; n_res = res; n_rem = rem; n_err = merr; end
      end
    end
    idle_c = resp_c + dr + 1;
    if (rst_busy >= 0 && b >= 0) rst_c = b + rst_busy;
    last = (rst_c >= 0) ? rst_c + 1 : idle_c;
    lim = (b >= 0) ? b : resp_c;
    for (int c = 0; c < last; c++) begin
      e_cmd_ready   = (c == 0);
      e_start       = (c != 1);
      e_load        = !(c == px || c == py);
      e_data        = (sy >= 0 && c >= sy) ? yv : ((sx >= 0 && c >= sx) ? x : prev_data);
      e_op          = (c >= 1) ? op : 2'd0;
      e_rsp_valid   = (c >= resp_c);
      e_rsp_result  = (c >= resp_c) ? n_res : prev_res;
      e_rsp_rem     = (c >= resp_c) ? n_rem : prev_rem;
      e_rsp_error   = (c >= resp_c) ? n_err : prev_err;
      e_rsp_timeout = (c >= resp_c) ? n_to : prev_to;
      chk_en = 1'b1;
      rst         = (c == rst_c);
      i_cmd_valid = (c == 0) || ($urandom_range(0, 3) == 0);
      i_cmd_op    = (c == 0) ? op : 2'($urandom_range(0, 3));
      i_cmd_x     = (c == 0) ? x : DW'($urandom);
      i_cmd_y     = (c == 0) ? y : DW'($urandom);
      i_load_x    = (dx < TMO && c == wx + dx);
      i_load_y    = (wy >= 0 && dy < TMO && c == wy + dy);
      i_error     = (abort_at == 1 && dx < TMO && c == wx + dx) ||
                    (abort_at == 2 && wy >= 0 && dy < TMO && c == wy + dy) ||
                    (b >= 0 && dd < TMO && c == b + dd && merr);
      i_done      = (b >= 0 && dd < TMO && c == b + dd) || (c < lim && $urandom_range(0, 5) == 0);
      i_result    = (b >= 0 && c == b + dd) ? res : DW'($urandom);
      i_remainder = (b >= 0 && c == b + dd) ? rem : DW'($urandom);
      i_rsp_ready = (c == resp_c + dr) || (c < resp_c && $urandom_range(0, 2) == 0);
      @(posedge clk); #1;
    end
    if (rst_c >= 0) begin
      prev_data = '0; prev_res = '0; prev_rem = '0; prev_err = 1'b0; prev_to = 1'b0;
    end else begin
      prev_data = (sy >= 0) ? yv : ((sx >= 0) ? x : prev_data);
      prev_res = n_res; prev_rem = n_rem; prev_err = n_err; prev_to = n_to;
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] op;
    logic [DW-1:0] x, y;
    int dx, dy, dd, dr, ab;
    rst = 1'b1;
    i_cmd_valid = 1'b0; i_cmd_op = 2'd0; i_cmd_x = '0; i_cmd_y = '0;
    i_load_x = 1'b0; i_load_y = 1'b0; i_done = 1'b0; i_error = 1'b0;
    i_result = '0; i_remainder = '0; i_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_strobes", {30'd0, o_start, o_load}, 32'd3);
    check("reset_ready", {31'd0, o_cmd_ready}, 32'd1);
    check("reset_data_op", {14'd0, o_op, o_data}, 32'd0);
    check("reset_rsp", {13'd0, o_rsp_valid, o_rsp_error, o_rsp_timeout, o_rsp_result}, 32'd0);

    run_txn(OP_MULT, 16'd6, 16'd7, 1, 2, 3, 0, 0, -1);
    check("mult_6x7", {15'd0, o_rsp_error, o_rsp_result}, 32'd42);
    run_txn(OP_ROOT, 16'd25, 16'd9, 0, 0, 2, 1, 0, -1);
    check("root_25", {o_rsp_remainder, o_rsp_result}, 32'd5);
    check("root_y_zero", 32'(o_data), 32'd0);
    run_txn(OP_DIV, 16'd17, 16'd5, 2, 1, 4, 3, 0, -1);
    check("div_17_5", {o_rsp_remainder, o_rsp_result}, {16'd2, 16'd3});
    run_txn(OP_MULT, 16'd9, 16'd9, 0, TMO + 3, 0, 1, 0, -1);
    check("tmo_y", {14'd0, o_rsp_error, o_rsp_timeout, o_rsp_result}, {14'd0, 2'b11, 16'd0});
    run_txn(OP_DIV, 16'd9, 16'd0, 1, 1, 2, 0, 0, -1);
    check("div0_err", {30'd0, o_rsp_error, o_rsp_timeout}, 32'd2);
    run_txn(OP_MULT, 16'd5, 16'd5, 2, 0, 0, 0, 1, -1);
    check("abort_x", {14'd0, o_rsp_error, o_rsp_timeout, o_rsp_result}, {14'd0, 2'b10, 16'd0});
    run_txn(OP_MULT, 16'd2, 16'd8, 0, 0, TMO - 1, 0, 0, -1);
    check("done_beats_tmo", {14'd0, o_rsp_error, o_rsp_timeout, o_rsp_result}, 32'd16);
    run_txn(OP_DIV, 16'd100, 16'd7, TMO, 0, 0, 2, 0, -1);
    check("tmo_x", {30'd0, o_rsp_error, o_rsp_timeout}, 32'd3);
    run_txn(OP_MULT, 16'd10, 16'd10, 1, 1, 10, 0, 0, 2);
    check("rst_busy_ready", {29'd0, o_cmd_ready, o_start, o_load}, 32'd7);
    check("rst_busy_rsp", {o_rsp_valid, o_rsp_error, o_rsp_timeout, o_op, o_data, o_rsp_result[10:0]}, 32'd0);
    run_txn(OP_MULT, 16'd3, 16'd4, 0, 1, 1, 0, 0, -1);
    check("mult_3x4", 32'(o_rsp_result), 32'd12);

    for (int n = 0; n < 200; n++) begin
      op = 2'($urandom_range(0, 2));
      x  = DW'($urandom);
      y  = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
      dx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TMO + 2)) : int'($urandom_range(0, 3));
      dy = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TMO + 2)) : int'($urandom_range(0, 3));
      dd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TMO + 2)) : int'($urandom_range(0, 5));
      dr = int'($urandom_range(0, 3));
      ab = int'($urandom_range(0, 9));
      run_txn(op, x, y, dx, dy, dd, dr, (ab == 0) ? 1 : ((ab == 1) ? 2 : 0),
              ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    // Idle tail: the driver must sit in IDLE with the last response held.
    e_cmd_ready = 1'b1; e_start = 1'b1; e_load = 1'b1; e_data = prev_data; e_op = 2'd0;
    e_rsp_valid = 1'b0; e_rsp_result = prev_res; e_rsp_rem = prev_rem;
    e_rsp_error = prev_err; e_rsp_timeout = prev_to;
    i_cmd_valid = 1'b0; i_load_x = 1'b0; i_load_y = 1'b0; i_done = 1'b0;
    i_error = 1'b0; i_rsp_ready = 1'b0; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mdr_driver.md
Name: mdr_driver

Overview:
- Command-side initiator for the mdr (multiply/divide/root) unit.
- Accepts one operation command (op, X, Y) over a valid/ready handshake.
- Sequences mdr's active-low start and load strobes and presents each operand on the data bus when mdr requests it.
- Waits for completion, then returns result, remainder and error status over a valid/ready response handshake. Sits between the system controller and mdr.

Parameters:
- DW, 16, operand/result width (matches mdr data width)
- TIMEOUT, 64, max cycles spent in any wait state before the transaction is aborted

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  driver idle, can accept command
- i_cmd_op  in  2  op_select_t (MULT/DIV/ROOT)
- i_cmd_x  in  DW  first operand
- i_cmd_y  in  DW  second operand (ignored for ROOT)
- o_start  out  1  mdr start strobe, active-low
- o_load  out  1  mdr load strobe, active-low
- o_data  out  DW  operand bus to mdr
- o_op  out  2  operation select to mdr
- i_load_x  in  1  mdr requests X operand
- i_load_y  in  1  mdr requests Y operand
- i_done  in  1  mdr result valid (single-cycle)
- i_result  in  DW  mdr result
- i_remainder  in  DW  mdr remainder
- i_error  in  1  mdr error flag
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response accepted
- o_rsp_result  out  DW  captured result
- o_rsp_remainder  out  DW  captured remainder
- o_rsp_error  out  1  mdr error or abort
- o_rsp_timeout  out  1  abort caused by timeout

Behaviour:
- Reset values: o_start=1, o_load=1, o_data=0, o_op=0, o_cmd_ready=1, o_rsp_valid=0, o_rsp_result=0, o_rsp_remainder=0, o_rsp_error=0, o_rsp_timeout=0. FSM in IDLE, timeout counter 0.
- Reset mid-transaction: everything returns to reset values at the next edge; the captured command is discarded.
- All outputs are registered.
- FSM states: IDLE, START, WAIT_X, SETUP_X, PULSE_X, WAIT_Y, SETUP_Y, PULSE_Y, BUSY, RESP.
- IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid: capture op, X, and Y. Y is forced to 0 when op==ROOT.
  - Drive o_op and go to START.
  - o_op holds until return to IDLE.
- START: o_start=0 for exactly one cycle, so the start strobe falls 1 cycle after command accept. Go to WAIT_X.
- WAIT_X: o_start=1. When i_load_x=1, set o_data=X and go to SETUP_X.
- SETUP_X: o_load=1 for one cycle, giving data one cycle of setup before the strobe.
- PULSE_X: o_load=0 for one cycle, o_data still X. Go to WAIT_Y. o_data holds X until replaced.
- WAIT_Y / SETUP_Y / PULSE_Y: same as the X states, using i_load_y and Y. Go to BUSY.
- BUSY: on i_done, capture i_result, i_remainder and i_error into the rsp registers (o_rsp_timeout=0) and go to RESP.
- RESP:
  - o_rsp_valid=1; rsp fields are stable while valid.
  - On i_rsp_ready, clear o_rsp_valid and go to IDLE. o_cmd_ready rises the same edge.
  - o_cmd_ready=0 in every state except IDLE.
- Error abort: i_error=1 in WAIT_X/WAIT_Y goes to RESP with result=0, remainder=0, error=1, timeout=0.
- Timeout counter:
  - Clears on every state transition.
  - Increments each cycle in WAIT_X, WAIT_Y and BUSY.
  - If it reaches TIMEOUT while still waiting, go to RESP with result=0, remainder=0, error=1, timeout=1.
  - Width is ceil(log2(TIMEOUT+1)) and it must never wrap.
- Simultaneous-event priority:
  - i_done and timeout in the same cycle: done wins.
  - i_error and i_load_x/y in the same cycle: error wins.
  - i_done seen outside BUSY is ignored.
- Strobe guarantees: o_start and o_load are never low in the same cycle. Each strobe is low for exactly one cycle per transaction step.

Test Plan:
- MULT X=6 Y=7: o_start low 1 cycle after accept; load pulses with o_data=6 then 7; i_done with result=42 gives o_rsp_result=42, error=0.
- ROOT X=25: o_data=25 at first load pulse, 0 at second; i_done with result=5, rem=0 gives rsp 5/0, error=0.
- DIV 17/5 with i_rsp_ready low 3 cycles: o_rsp_valid held with 3/2 stable; o_cmd_ready=0 until handshake, then 1.
- TIMEOUT=16 and i_load_y never asserted: after 16 cycles in WAIT_Y, o_rsp_error=1, o_rsp_timeout=1, result=0.
- DIV by 0: i_done together with i_error=1 gives o_rsp_error=1, timeout=0. Separately, i_error and i_load_x asserted together in WAIT_X abort with no load pulse.
- rst asserted in BUSY: next cycle all outputs at reset values, o_cmd_ready=1; a new MULT 3x4 then completes with 12.
